// File: rtl/fifo_sram_responder.sv
// Responder side of the packed-FIFO SRAM interface: 1-cycle write-first memory with
// a post-reset clear engine, per-word even parity and an independent debug read port.
module fifo_sram_responder #(
  parameter int unsigned depth          = 64,
  parameter int unsigned sram_datawidth = 128,
  parameter int unsigned cnt_width      = 16,
  localparam int unsigned AW            = $clog2(depth)
) (
  input  logic                      axis_clk,
  input  logic                      axi_reset_n,
  input  logic                      sram_we,
  input  logic [AW-1:0]             sram_addr,
  input  logic [sram_datawidth-1:0] sram_din,
  output logic [sram_datawidth-1:0] sram_dout,
  input  logic                      inj_par_err,
  output logic                      par_err,
  output logic                      par_err_sticky,
  input  logic                      err_clr,
  output logic                      init_done,
  input  logic                      dbg_rd,
  input  logic [AW-1:0]             dbg_addr,
  output logic                      dbg_vld,
  output logic [sram_datawidth-1:0] dbg_data,
  output logic [cnt_width-1:0]      wr_count
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                      state_q, state_d;
  logic [AW-1:0]               clr_ptr_q, clr_ptr_d;
  logic [depth-1:0]            written_q, written_d;
  logic                        clr_en;

  logic [sram_datawidth-1:0]   mem [depth];
  logic [depth-1:0]            par_mem;

  logic [sram_datawidth-1:0]   dout_q, dout_d;
  logic                        par_err_q, par_err_d;
  logic                        sticky_q, sticky_d;
  logic                        dbg_vld_q;
  logic [sram_datawidth-1:0]   dbg_data_q, dbg_data_d;
  logic [cnt_width-1:0]        wr_count_q, wr_count_d;

  logic [sram_datawidth-1:0]   rd_word, dbg_word;
  logic                        rd_masked, dbg_masked;

  // Clear engine: one word per cycle, skipping words the client already wrote.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_en    = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_en    = ~written_q[clr_ptr_q] & ~(sram_we & (sram_addr == clr_ptr_q));
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(depth - 1)) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_comb begin
    written_d = written_q;
    if (sram_we) begin
      written_d[sram_addr] = 1'b1;
    end
  end

  // Array contents are never reset; only the clear engine zeroes them.
  always_ff @(posedge axis_clk) begin
    if (sram_we) begin
      mem[sram_addr]     <= sram_din;
      par_mem[sram_addr] <= (^sram_din) ^ inj_par_err;
    end
    if (clr_en && axi_reset_n) begin
      mem[clr_ptr_q]     <= '0;
      par_mem[clr_ptr_q] <= 1'b0;
    end
  end

  // Words not yet reached by the clear engine read as zero.
  assign rd_masked  = (state_q == StClear) && !written_q[sram_addr] &&
                      (sram_addr >= clr_ptr_q);
  assign dbg_masked = (state_q == StClear) && !written_q[dbg_addr] &&
                      (dbg_addr >= clr_ptr_q);
  assign rd_word    = mem[sram_addr];
  assign dbg_word   = mem[dbg_addr];

  always_comb begin
    dout_d    = rd_word;
    par_err_d = (^rd_word) != par_mem[sram_addr];
    if (sram_we) begin
      dout_d    = sram_din;
      par_err_d = inj_par_err;
    end else if (rd_masked) begin
      dout_d    = '0;
      par_err_d = 1'b0;
    end
  end

  always_comb begin
    dbg_data_d = dbg_data_q;
    if (dbg_rd) begin
      if (sram_we && (sram_addr == dbg_addr)) begin
        dbg_data_d = sram_din;
      end else if (dbg_masked) begin
        dbg_data_d = '0;
      end else begin
        dbg_data_d = dbg_word;
      end
    end
  end

  // Clear wins over a same-cycle error so firmware never loses the acknowledge.
  assign sticky_d   = err_clr ? 1'b0 : (sticky_q | par_err_d);
  assign wr_count_d = (sram_we && (wr_count_q != '1)) ? wr_count_q + cnt_width'(1) : wr_count_q;

  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      written_q  <= '0;
      dout_q     <= '0;
      par_err_q  <= 1'b0;
      sticky_q   <= 1'b0;
      dbg_vld_q  <= 1'b0;
      dbg_data_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      written_q  <= written_d;
      dout_q     <= dout_d;
      par_err_q  <= par_err_d;
      sticky_q   <= sticky_d;
      dbg_vld_q  <= dbg_rd;
      dbg_data_q <= dbg_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign sram_dout      = dout_q;
  assign par_err        = par_err_q;
  assign par_err_sticky = sticky_q;
  assign init_done      = (state_q == StReady);
  assign dbg_vld        = dbg_vld_q;
  assign dbg_data       = dbg_data_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_fifo_sram_responder.sv
// Directed bench for fifo_sram_responder; expected outputs are queued when stimulus is
// driven and compared one cycle later when the registered outputs appear.
module tb_fifo_sram_responder;

  logic         axis_clk = 1'b0;
  logic         axi_reset_n = 1'b0;
  logic         sram_we = 1'b0;
  logic [5:0]   sram_addr = '0;
  logic [127:0] sram_din = '0;
  logic         inj_par_err = 1'b0;
  logic         err_clr = 1'b0;
  logic         dbg_rd = 1'b0;
  logic [5:0]   dbg_addr = '0;
  logic [127:0] sram_dout;
  logic         par_err;
  logic         par_err_sticky;
  logic         init_done;
  logic         dbg_vld;
  logic [127:0] dbg_data;
  logic [15:0]  wr_count;

  int checks = 0;
  int errors = 0;
  logic [15:0]  exp_cnt = '0;

  string        ctag_q[$];
  logic [127:0] cdat_q[$];
  logic         cpe_q[$];
  string        dtag_q[$];
  logic [127:0] ddat_q[$];

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] X  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] Z  = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;
  localparam logic [127:0] D  = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] Y  = 128'h5a5a_5a5a_1234_5678_9abc_def0_0f0f_0f0f;

  fifo_sram_responder dut (
    .axis_clk       (axis_clk),
    .axi_reset_n    (axi_reset_n),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_din       (sram_din),
    .sram_dout      (sram_dout),
    .inj_par_err    (inj_par_err),
    .par_err        (par_err),
    .par_err_sticky (par_err_sticky),
    .err_clr        (err_clr),
    .init_done      (init_done),
    .dbg_rd         (dbg_rd),
    .dbg_addr       (dbg_addr),
    .dbg_vld        (dbg_vld),
    .dbg_data       (dbg_data),
    .wr_count       (wr_count)
  );

  always #5 axis_clk = ~axis_clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [5:0] a, input logic [127:0] d,
                       input logic inj, input logic clr, input logic drd, input logic [5:0] da);
    sram_we     = we;
    sram_addr   = a;
    sram_din    = d;
    inj_par_err = inj;
    err_clr     = clr;
    dbg_rd      = drd;
    dbg_addr    = da;
    if (we && axi_reset_n && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, '0, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic exp_c(input string tag, input logic [127:0] d, input logic pe);
    ctag_q.push_back(tag);
    cdat_q.push_back(d);
    cpe_q.push_back(pe);
  endtask

  task automatic exp_d(input string tag, input logic [127:0] d);
    dtag_q.push_back(tag);
    ddat_q.push_back(d);
  endtask

  task automatic step();
    string t;
    @(posedge axis_clk);
    #1;
    if (ctag_q.size() > 0) begin
      t = ctag_q.pop_front();
      chk({t, "_dout"}, sram_dout, cdat_q.pop_front());
      chk({t, "_par_err"}, {127'd0, par_err}, {127'd0, cpe_q.pop_front()});
    end
    if (dtag_q.size() > 0) begin
      t = dtag_q.pop_front();
      chk({t, "_vld"}, {127'd0, dbg_vld}, 128'd1);
      chk({t, "_data"}, dbg_data, ddat_q.pop_front());
    end else begin
      chk("dbg_vld_idle", {127'd0, dbg_vld}, 128'd0);
    end
  endtask

  initial begin
    // Reset values
    axi_reset_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_dout", sram_dout, '0);
    chk("rst_par_err", {127'd0, par_err}, '0);
    chk("rst_sticky", {127'd0, par_err_sticky}, '0);
    chk("rst_init_done", {127'd0, init_done}, '0);
    chk("rst_dbg_data", dbg_data, '0);
    chk("rst_wr_count", {112'd0, wr_count}, '0);

    // Clear phase with a client write to addr 5 at cycle 3
    axi_reset_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 1) begin
        drive(1'b0, 6'd40, '0, 1'b0, 1'b0, 1'b0, 6'd0);
        exp_c("clr_mask_rd40", '0, 1'b0);
      end else if (k == 3) begin
        drive(1'b1, 6'd5, A5, 1'b0, 1'b0, 1'b0, 6'd0);
        exp_c("wr5_during_clear", A5, 1'b0);
      end else if (k == 7) begin
        drive(1'b0, 6'd0, '0, 1'b0, 1'b0, 1'b1, 6'd50);
        exp_d("dbg_clr_mask50", '0);
      end else begin
        idle();
      end
      step();
      if (k == 62) chk("init_done_at_63", {127'd0, init_done}, '0);
      if (k == 63) chk("init_done_at_64", {127'd0, init_done}, 128'd1);
    end

    drive(1'b0, 6'd0, '0, 1'b0, 1'b0, 1'b1, 6'd0);  exp_d("dbg0", '0);  step();
    drive(1'b0, 6'd0, '0, 1'b0, 1'b0, 1'b1, 6'd31); exp_d("dbg31", '0); step();
    drive(1'b0, 6'd0, '0, 1'b0, 1'b0, 1'b1, 6'd63); exp_d("dbg63", '0); step();
    drive(1'b0, 6'd5, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd5", A5, 1'b0); step();
    drive(1'b0, 6'd6, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd6", '0, 1'b0); step();

    // Read latency and write-first
    drive(1'b1, 6'd10, X, 1'b0, 1'b0, 1'b0, 6'd0);   exp_c("wr10", X, 1'b0); step();
    drive(1'b0, 6'd10, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd10", X, 1'b0); step();
    drive(1'b1, 6'd11, Z, 1'b0, 1'b0, 1'b0, 6'd0);   exp_c("wr11_first", Z, 1'b0); step();
    drive(1'b0, 6'd11, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd11_b2b", Z, 1'b0); step();

    // Parity injection, sticky flag and clear priority
    drive(1'b1, 6'd20, D, 1'b1, 1'b0, 1'b0, 6'd0);   exp_c("wr20_inj", D, 1'b1); step();
    chk("sticky_after_inj", {127'd0, par_err_sticky}, 128'd1);
    drive(1'b0, 6'd21, '0, 1'b0, 1'b1, 1'b0, 6'd0);  exp_c("rd21_clr", '0, 1'b0); step();
    chk("sticky_cleared", {127'd0, par_err_sticky}, '0);
    drive(1'b0, 6'd20, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd20_bad", D, 1'b1); step();
    chk("sticky_on_read", {127'd0, par_err_sticky}, 128'd1);
    drive(1'b0, 6'd21, '0, 1'b0, 1'b1, 1'b0, 6'd0);  exp_c("rd21_good", '0, 1'b0); step();
    chk("sticky_cleared2", {127'd0, par_err_sticky}, '0);
    drive(1'b0, 6'd20, '0, 1'b0, 1'b1, 1'b0, 6'd0);  exp_c("rd20_clr_prio", D, 1'b1); step();
    chk("sticky_clr_priority", {127'd0, par_err_sticky}, '0);
    drive(1'b0, 6'd21, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd21_again", '0, 1'b0); step();
    chk("sticky_stays_low", {127'd0, par_err_sticky}, '0);

    // Debug port collision and no parity reporting from debug reads
    drive(1'b1, 6'd10, Y, 1'b0, 1'b0, 1'b1, 6'd10);
    exp_c("wr10_y", Y, 1'b0);
    exp_d("dbg_collide10", Y);
    step();
    drive(1'b0, 6'd5, '0, 1'b0, 1'b0, 1'b1, 6'd20);
    exp_c("rd5_while_dbg20", A5, 1'b0);
    exp_d("dbg20_bad_par", D);
    step();
    drive(1'b0, 6'd10, '0, 1'b0, 1'b0, 1'b0, 6'd0);  exp_c("rd10_y", Y, 1'b0); step();
    chk("wr_count_5", {112'd0, wr_count}, {112'd0, exp_cnt});

    // Write counter saturation
    while (exp_cnt != 16'hFFFD) begin
      drive(1'b1, 6'($urandom_range(63)), {$urandom, $urandom, $urandom, $urandom},
            1'b0, 1'b0, 1'b0, 6'd0);
      step();
    end
    idle();
    step();
    chk("wr_count_fffd", {112'd0, wr_count}, 128'hFFFD);
    drive(1'b1, 6'd1, '0, 1'b0, 1'b0, 1'b0, 6'd0); step();
    chk("wr_count_fffe", {112'd0, wr_count}, 128'hFFFE);
    drive(1'b1, 6'd2, '0, 1'b0, 1'b0, 1'b0, 6'd0); step();
    chk("wr_count_ffff", {112'd0, wr_count}, 128'hFFFF);
    drive(1'b1, 6'd3, '0, 1'b0, 1'b0, 1'b0, 6'd0); step();
    chk("wr_count_sat", {112'd0, wr_count}, 128'hFFFF);

    // Reset in the middle of a clear pass
    axi_reset_n = 1'b0;
    idle();
    step();
    axi_reset_n = 1'b1;
    exp_cnt = '0;
    for (int k = 0; k < 30; k++) step();
    axi_reset_n = 1'b0;
    step();
    chk("midrst_init_done", {127'd0, init_done}, '0);
    chk("midrst_wr_count", {112'd0, wr_count}, '0);
    chk("midrst_dout", sram_dout, '0);
    axi_reset_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (k == 62) chk("reclear_done_63", {127'd0, init_done}, '0);
      if (k == 63) chk("reclear_done_64", {127'd0, init_done}, 128'd1);
    end
    drive(1'b0, 6'd10, '0, 1'b0, 1'b0, 1'b1, 6'd5);
    exp_c("rd10_after_reclear", '0, 1'b0);
    exp_d("dbg5_after_reclear", '0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
